// File: rtl/vagas_pkg.sv
// Shared types and mapping helpers for the parking vacancy controller.
package vagas_pkg;

  localparam int unsigned N_VAGAS = 8;
  localparam int unsigned N_LIN   = 4;

  localparam logic [1:0] COL_ODD  = 2'b01;
  localparam logic [1:0] COL_EVEN = 2'b10;

  typedef enum logic [1:0] {IDLE, ACK, RESV, NEG} state_t;

  // Lin[j] shows space (3-j)*2 + (1-phase): phase 0 drives odd spaces, phase 1 even.
  function automatic logic [2:0] lin_space(input logic phase, input logic [1:0] j);
    return {~j, ~phase};
  endfunction

  function automatic logic [2:0] lowest_free(input logic [N_VAGAS-1:0] occ);
    logic [2:0] idx;
    idx = '0;
    for (int i = N_VAGAS - 1; i >= 0; i--) begin
      if (!occ[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] free_count(input logic [N_VAGAS-1:0] occ);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < N_VAGAS; i++) begin
      n = n + {3'b000, ~occ[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/debounce_vaga.sv
// One space sensor: 2-FF synchroniser followed by a consecutive-difference debouncer.
module debounce_vaga #(
  parameter int unsigned DEB_CYCLES = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_stable
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/gerenciador_vagas.sv
// Parking vacancy controller: sensor debounce, LED column scan, free count and
// entry-gate Req/Ack arbitration with a single timed reservation.
module gerenciador_vagas
  import vagas_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned DEB_CYCLES  = 1000,
  parameter int unsigned RES_TIMEOUT = 5000000
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [7:0] CH,
  input  logic       Req,
  output logic [1:0] Col,
  output logic [3:0] Lin,
  output logic [3:0] Livres,
  output logic       Cheio,
  output logic       Ack,
  output logic       Negado,
  output logic [2:0] Vaga
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned TW = $clog2(RES_TIMEOUT);

  logic [N_VAGAS-1:0] w_stable;
  logic [N_VAGAS-1:0] w_occ;
  logic [N_VAGAS-1:0] r_reserved;
  logic [PW-1:0]      r_presc;
  logic               r_phase;
  logic [TW-1:0]      r_timer;
  logic [2:0]         r_vaga;
  state_t             r_state;
  state_t             w_state_next;
  logic               w_grant;
  logic               w_release;
  logic               w_arrived;
  logic [3:0]         w_free;
  logic [3:0]         w_lin;

  for (genvar g = 0; g < N_VAGAS; g++) begin : g_deb
    debounce_vaga #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .i_clk   (Clock),
      .i_rst_n (Reset_n),
      .i_raw   (CH[g]),
      .o_stable(w_stable[g])
    );
  end

  assign w_occ     = w_stable | r_reserved;
  assign w_free    = free_count(w_occ);
  assign w_arrived = w_stable[r_vaga];

  always_comb begin
    w_lin = '0;
    for (int j = 0; j < N_LIN; j++) begin
      w_lin[j] = ~w_occ[lin_space(r_phase, 2'(j))];
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_presc <= '0;
      r_phase <= 1'b0;
      Col     <= 2'b00;
      Lin     <= 4'b0000;
      Livres  <= 4'd8;
      Cheio   <= 1'b0;
    end else begin
      if (r_presc == PW'(SCAN_DIV - 1)) begin
        r_presc <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      Col    <= r_phase ? COL_EVEN : COL_ODD;
      Lin    <= w_lin;
      Livres <= w_free;
      Cheio  <= (w_free == 4'd0);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_release    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (Req && (|(~w_occ))) begin
          w_state_next = ACK;
          w_grant      = 1'b1;
        end else if (Req && Cheio) begin
          w_state_next = NEG;
        end
      end
      ACK: begin
        if (!Req) w_state_next = RESV;
      end
      RESV: begin
        if (w_arrived || (r_timer == TW'(RES_TIMEOUT - 1))) begin
          w_state_next = IDLE;
          w_release    = 1'b1;
        end
      end
      NEG: begin
        if (!Req) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_reserved <= '0;
      r_vaga     <= '0;
      r_timer    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_reserved[lowest_free(w_occ)] <= 1'b1;
        r_vaga                         <= lowest_free(w_occ);
        r_timer                        <= '0;
      end else begin
        // An arrival while still in ACK frees the slot early; RESV exits on the next cycle.
        if (w_release || ((r_state == ACK) && w_arrived)) r_reserved[r_vaga] <= 1'b0;
        if (((r_state == ACK) || (r_state == RESV)) && (r_timer != TW'(RES_TIMEOUT - 1))) begin
          r_timer <= r_timer + 1'b1;
        end
      end
    end
  end

  assign Ack    = (r_state == ACK);
  assign Negado = (r_state == NEG);
  assign Vaga   = r_vaga;

endmodule
